// File: rtl/d_lock_sequencer.sv
// d_lock_sequencer: top-level control FSM for the electronic door lock.
// Collects keypad digits, checks them against a stored password, counts
// wrong attempts and drives the timer/LED datapath control lines.
// Optional feature: define MASTER_CODE_EN to also accept the all-nines
// master code in CHECK (default build: password comparator only).
module d_lock_sequencer #(
    parameter int unsigned          DIGITS      = 4,
    parameter logic [DIGITS*4-1:0]  PASSWORD    = 16'h1234,
    parameter int unsigned          MAX_ERR     = 3,
    parameter int unsigned          OPEN_CYCLES = 640000000,
    parameter int unsigned          LOCK_CYCLES = 1280000000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_val,
    input  logic       key_enter,
    input  logic       key_clear,
    input  logic       set_req,
    input  logic       door_closed,
    output logic       enb_lock,
    output logic       enb_cnt,
    output logic       disable_cnt,
    output logic       ignore,
    output logic       gen_stop,
    output logic [2:0] error_counter,
    output logic [2:0] state,
    output logic [2:0] digit_cnt
);

    localparam int unsigned CODE_W    = DIGITS * 4;
    localparam logic [2:0]  DIGITS_C  = 3'(DIGITS);
    localparam logic [2:0]  MAX_ERR_C = 3'(MAX_ERR);
    localparam logic [31:0] OPEN_LAST = 32'(OPEN_CYCLES - 1);
    localparam logic [31:0] LOCK_LAST = 32'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_FAIL    = 3'd4,
        S_LOCKOUT = 3'd5,
        S_SET     = 3'd6
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CODE_W-1:0]   entry_q;
    logic [CODE_W-1:0]   password_q;
    logic [CODE_W-1:0]   entry_shift;
    logic [31:0]         timer_q;
    logic                digit_ok;
    logic                entry_full;
    logic                code_match;
    logic                open_done;
    logic                lock_done;

    assign state       = state_q;
    assign digit_ok    = key_valid && (key_val <= 4'd9);
    assign entry_full  = (digit_cnt == DIGITS_C);
    // Newest digit enters at the LSB so the first digit typed ends up in the MSB.
    assign entry_shift = {entry_q[CODE_W-5:0], key_val};
    // Door must be closed before the open interval may end; timer saturates meanwhile.
    assign open_done   = (timer_q == OPEN_LAST) && door_closed;
    assign lock_done   = (timer_q == LOCK_LAST);

`ifdef MASTER_CODE_EN
    localparam logic [CODE_W-1:0] MASTER_CODE = {DIGITS{4'h9}};
    assign code_match = entry_full && ((entry_q == password_q) || (entry_q == MASTER_CODE));
`else
    assign code_match = entry_full && (entry_q == password_q);
`endif

    // Next-state decode; clear beats enter beats digit, expiry beats set_req.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (digit_ok) state_d = S_ENTRY;
            S_ENTRY: begin
                if (key_clear)      state_d = S_IDLE;
                else if (key_enter) state_d = S_CHECK;
            end
            S_CHECK:   state_d = code_match ? S_OPEN : S_FAIL;
            S_FAIL:    state_d = (error_counter == MAX_ERR_C) ? S_LOCKOUT : S_IDLE;
            S_OPEN: begin
                if (open_done)    state_d = S_IDLE;
                else if (set_req) state_d = S_SET;
            end
            S_SET:     if (key_clear || key_enter) state_d = S_OPEN;
            S_LOCKOUT: if (lock_done) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State, timer, entry, password and registered outputs (derived from next state).
    always_ff @(posedge clk_in) begin
        if (reset) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= S_IDLE;
            enb_lock      <= 1'b1;
            enb_cnt       <= 1'b0;
            disable_cnt   <= 1'b1;
            ignore        <= 1'b0;
            gen_stop      <= 1'b0;
            error_counter <= 3'd0;
            digit_cnt     <= 3'd0;
            entry_q       <= '0;
            password_q    <= PASSWORD;
            timer_q       <= 32'd0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q)
                timer_q <= 32'd0;
            else if ((state_q == S_OPEN && timer_q != OPEN_LAST) || state_q == S_LOCKOUT)
                timer_q <= timer_q + 32'd1;

            gen_stop    <= (state_q == S_OPEN || state_q == S_LOCKOUT) && (state_d == S_IDLE);
            enb_lock    <= !(state_d == S_OPEN || state_d == S_SET);
            enb_cnt     <= (state_d == S_OPEN || state_d == S_LOCKOUT);
            disable_cnt <= (state_d == S_IDLE);
            ignore      <= (state_d == S_CHECK || state_d == S_FAIL || state_d == S_LOCKOUT);

            case (state_q)
                S_IDLE: begin
                    if (digit_ok) begin
                        entry_q   <= entry_shift;
                        digit_cnt <= 3'd1;
                    end
                end
                S_ENTRY, S_SET: begin
                    if (key_clear || (key_enter && state_q == S_SET)) begin
                        entry_q   <= '0;
                        digit_cnt <= 3'd0;
                    end else if (!key_enter && digit_ok && digit_cnt < DIGITS_C) begin
                        entry_q   <= entry_shift;
                        digit_cnt <= digit_cnt + 3'd1;
                    end
                end
                S_CHECK: begin
                    entry_q   <= '0;
                    digit_cnt <= 3'd0;
                end
                default: ;
            endcase

            if (state_q == S_CHECK)
                error_counter <= code_match ? 3'd0 : error_counter + 3'd1;
            else if (state_q == S_LOCKOUT && lock_done)
                error_counter <= 3'd0;

            if (state_q == S_SET && !key_clear && key_enter && entry_full)
                password_q <= entry_q;
        end
    end

endmodule

// File: tb/tb_d_lock_sequencer.sv
// tb_d_lock_sequencer: table vectors, directed multi-cycle sequences and a
// randomized run compared cycle by cycle against a behavioural lock model.
module tb_d_lock_sequencer;

    localparam int OPEN_N = 20;
    localparam int LOCK_N = 30;
    localparam int P_IDLE = 0, P_ENTRY = 1, P_CHECK = 2, P_OPEN = 3,
                   P_FAIL = 4, P_LOCKOUT = 5, P_SET = 6;
    localparam logic [13:0] RESET_OUTS = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0};

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_val = 4'd0;
    logic       key_enter = 1'b0;
    logic       key_clear = 1'b0;
    logic       set_req = 1'b0;
    logic       door_closed = 1'b1;
    logic       enb_lock, enb_cnt, disable_cnt, ignore, gen_stop;
    logic [2:0] error_counter, state, digit_cnt;
    logic [13:0] dut_outs;

    int total = 0;
    int bad = 0;
    logic dc_level = 1'b1;

    // Behavioural model: phase, typed digits, attempt count, password, time in phase.
    int m_phase = P_IDLE;
    int m_digits[$];
    int m_errs = 0;
    int m_pw = 'h1234;
    int m_elapsed = 0;
    bit m_stop = 0;

    typedef struct {
        logic       kv;
        logic [3:0] kval;
        logic       ke;
        logic       kc;
        logic [2:0] st;
        logic [2:0] dcnt;
        logic [2:0] err;
        logic       lock;
    } vec_t;
    vec_t vq[$];

    d_lock_sequencer #(
        .DIGITS(4), .PASSWORD(16'h1234), .MAX_ERR(3),
        .OPEN_CYCLES(OPEN_N), .LOCK_CYCLES(LOCK_N)
    ) dut (
        .clk_in(clk_in), .reset(reset), .key_valid(key_valid), .key_val(key_val),
        .key_enter(key_enter), .key_clear(key_clear), .set_req(set_req),
        .door_closed(door_closed), .enb_lock(enb_lock), .enb_cnt(enb_cnt),
        .disable_cnt(disable_cnt), .ignore(ignore), .gen_stop(gen_stop),
        .error_counter(error_counter), .state(state), .digit_cnt(digit_cnt)
    );

    assign dut_outs = {enb_lock, enb_cnt, disable_cnt, ignore, gen_stop,
                       error_counter, state, digit_cnt};

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int code_value();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return v;
    endfunction

    function automatic logic [13:0] model_outs();
        logic lk, cn, ds, ig;
        lk = !(m_phase == P_OPEN || m_phase == P_SET);
        cn = (m_phase == P_OPEN || m_phase == P_LOCKOUT);
        ds = (m_phase == P_IDLE);
        ig = (m_phase == P_CHECK || m_phase == P_FAIL || m_phase == P_LOCKOUT);
        return {lk, cn, ds, ig, m_stop, 3'(m_errs), 3'(m_phase), 3'(m_digits.size())};
    endfunction

    task automatic model_step(input logic rst, input logic kv, input logic [3:0] kval,
                              input logic ke, input logic kc, input logic sr, input logic dc);
        int  prev;
        bit  valid;
        bit  ok;
        m_stop = 0;
        if (rst) begin
            m_phase = P_IDLE;
            m_digits.delete();
            m_errs = 0;
            m_pw = 'h1234;
            m_elapsed = 0;
            return;
        end
        prev  = m_phase;
        valid = kv && (kval <= 9);
        case (m_phase)
            P_IDLE: if (valid) begin
                m_digits.delete();
                m_digits.push_back(int'(kval));
                m_phase = P_ENTRY;
            end
            P_ENTRY: begin
                if (kc) begin
                    m_digits.delete();
                    m_phase = P_IDLE;
                end else if (ke) m_phase = P_CHECK;
                else if (valid && m_digits.size() < 4) m_digits.push_back(int'(kval));
            end
            P_CHECK: begin
                ok = (m_digits.size() == 4) && (code_value() == m_pw);
`ifdef MASTER_CODE_EN
                if (m_digits.size() == 4 && code_value() == 'h9999) ok = 1;
`endif
                if (ok) begin
                    m_errs = 0;
                    m_phase = P_OPEN;
                end else begin
                    m_errs++;
                    m_phase = P_FAIL;
                end
                m_digits.delete();
            end
            P_FAIL: m_phase = (m_errs == 3) ? P_LOCKOUT : P_IDLE;
            P_OPEN: begin
                if (m_elapsed >= OPEN_N - 1 && dc) begin
                    m_stop = 1;
                    m_phase = P_IDLE;
                end else if (sr) m_phase = P_SET;
            end
            P_SET: begin
                if (kc) begin
                    m_digits.delete();
                    m_phase = P_OPEN;
                end else if (ke) begin
                    if (m_digits.size() == 4) m_pw = code_value();
                    m_digits.delete();
                    m_phase = P_OPEN;
                end else if (valid && m_digits.size() < 4) m_digits.push_back(int'(kval));
            end
            P_LOCKOUT: if (m_elapsed == LOCK_N - 1) begin
                m_stop = 1;
                m_errs = 0;
                m_phase = P_IDLE;
            end
            default: m_phase = P_IDLE;
        endcase
        if (m_phase != prev) m_elapsed = 0;
        else m_elapsed++;
    endtask

    task automatic step(input logic rst, input logic kv, input logic [3:0] kval,
                        input logic ke, input logic kc, input logic sr, input logic dc);
        reset = rst; key_valid = kv; key_val = kval; key_enter = ke;
        key_clear = kc; set_req = sr; door_closed = dc;
        model_step(rst, kv, kval, ke, kc, sr, dc);
        @(posedge clk_in);
        #1;
        check("outs_vs_model", 32'(dut_outs), 32'(model_outs()));
        reset = 1'b0; key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; set_req = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, dc_level);
    endtask

    task automatic press(input logic [3:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, dc_level);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, dc_level);
    endtask

    // Four digits (first digit in the top nibble) followed by key_enter.
    task automatic enter_code(input logic [15:0] code);
        for (int i = 0; i < 4; i++) press(code[15 - 4*i -: 4]);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, dc_level);
    endtask

    task automatic wait_stop(input int exp_cycles, input string name);
        int n = 0;
        do begin
            idle();
            n++;
        end while (!gen_stop && n < 200);
        check(name, 32'(n), 32'(exp_cycles));
    endtask

    task automatic add_vec(input int kv, input int kval, input int ke, input int kc,
                           input int st, input int dcnt, input int err, input int lock);
        vec_t v;
        v.kv = 1'(kv); v.kval = 4'(kval); v.ke = 1'(ke); v.kc = 1'(kc);
        v.st = 3'(st); v.dcnt = 3'(dcnt); v.err = 3'(err); v.lock = 1'(lock);
        vq.push_back(v);
    endtask

    initial begin
        int stops;
        logic       rkv, rke, rkc, rsr, rdc, rrst;
        logic [3:0] rval;
        int         pos;

        //      kv val ke kc  st dcnt err lock
        add_vec(1, 1, 0, 0,   1, 1, 0, 1);
        add_vec(1, 2, 0, 0,   1, 2, 0, 1);
        add_vec(0, 0, 1, 0,   2, 2, 0, 1);   // short entry -> CHECK
        add_vec(0, 0, 0, 0,   4, 0, 1, 1);   // FAIL, one error
        add_vec(0, 0, 0, 0,   0, 0, 1, 1);
        add_vec(1, 1, 0, 0,   1, 1, 1, 1);
        add_vec(1, 2, 0, 0,   1, 2, 1, 1);
        add_vec(0, 0, 1, 1,   0, 0, 1, 1);   // clear wins over enter
        add_vec(1, 15, 0, 0,  0, 0, 1, 1);   // non-digit ignored in IDLE
        add_vec(0, 0, 1, 0,   0, 0, 1, 1);   // enter ignored in IDLE
        add_vec(1, 1, 0, 0,   1, 1, 1, 1);
        add_vec(1, 2, 0, 0,   1, 2, 1, 1);
        add_vec(1, 3, 0, 0,   1, 3, 1, 1);
        add_vec(1, 4, 0, 0,   1, 4, 1, 1);
        add_vec(1, 5, 0, 0,   1, 4, 1, 1);   // fifth digit dropped
        add_vec(0, 0, 1, 0,   2, 4, 1, 1);
        add_vec(0, 0, 0, 0,   3, 0, 0, 0);   // OPEN, errors cleared

        do_reset();
        check("reset_outs", 32'(dut_outs), 32'(RESET_OUTS));

        foreach (vq[i]) begin
            step(1'b0, vq[i].kv, vq[i].kval, vq[i].ke, vq[i].kc, 1'b0, dc_level);
            check("vec_state", 32'(state), 32'(vq[i].st));
            check("vec_digit_cnt", 32'(digit_cnt), 32'(vq[i].dcnt));
            check("vec_error_counter", 32'(error_counter), 32'(vq[i].err));
            check("vec_enb_lock", 32'(enb_lock), 32'(vq[i].lock));
        end

        // Open interval expiry with the door closed.
        wait_stop(OPEN_N, "open_expiry_cycles");
        check("open_expiry_state", 32'(state), 32'd0);
        check("open_expiry_lock", 32'(enb_lock), 32'd1);
        idle();
        check("gen_stop_one_cycle", 32'(gen_stop), 32'd0);

        // Three wrong attempts lead to lockout.
        for (int k = 1; k <= 3; k++) begin
            enter_code(16'h1111);
            check("wrong_check_state", 32'(state), 32'd2);
            idle();
            check("wrong_fail_state", 32'(state), 32'd4);
            check("wrong_err_step", 32'(error_counter), 32'(k));
            idle();
            check("wrong_after_fail", 32'(state), (k < 3) ? 32'd0 : 32'd5);
        end
        check("lockout_ignore", 32'(ignore), 32'd1);
        for (int i = 0; i < 3; i++) begin
            press(4'd5);
            check("lockout_digit_cnt", 32'(digit_cnt), 32'd0);
        end
        wait_stop(LOCK_N - 3, "lockout_cycles");
        check("lockout_end_err", 32'(error_counter), 32'd0);
        check("lockout_end_state", 32'(state), 32'd0);

        // Password change while unlocked.
        enter_code(16'h1234);
        idle();
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, dc_level);
        check("set_state", 32'(state), 32'd6);
        check("set_enb_lock", 32'(enb_lock), 32'd0);
        check("set_enb_cnt", 32'(enb_cnt), 32'd0);
        enter_code(16'h5678);
        check("set_back_open", 32'(state), 32'd3);
        wait_stop(OPEN_N, "open_after_set_cycles");
        enter_code(16'h1234);
        idle();
        check("old_pw_fails", 32'(state), 32'd4);
        check("old_pw_err", 32'(error_counter), 32'd1);
        idle();
        enter_code(16'h5678);
        idle();
        check("new_pw_opens", 32'(state), 32'd3);
        check("new_pw_err", 32'(error_counter), 32'd0);
        wait_stop(OPEN_N, "open_new_pw_cycles");
        do_reset();
        check("reset_mid_outs", 32'(dut_outs), 32'(RESET_OUTS));
        enter_code(16'h1234);
        idle();
        check("pw_restored", 32'(state), 32'd3);

        // Door held open past expiry.
        dc_level = 1'b0;
        stops = 0;
        for (int i = 0; i < 30; i++) begin
            idle();
            if (gen_stop) stops++;
        end
        check("door_open_no_stop", 32'(stops), 32'd0);
        check("door_open_state", 32'(state), 32'd3);
        dc_level = 1'b1;
        idle();
        check("door_close_stop", 32'(gen_stop), 32'd1);
        check("door_close_state", 32'(state), 32'd0);

        // Reset in the middle of a lockout.
        for (int k = 0; k < 3; k++) begin
            enter_code(16'h1111);
            idle();
            idle();
        end
        check("lock_again_state", 32'(state), 32'd5);
        repeat (10) idle();
        do_reset();
        check("reset_in_lockout", 32'(dut_outs), 32'(RESET_OUTS));

        // Master code: opens only when the feature is built in.
        enter_code(16'h9999);
        idle();
`ifdef MASTER_CODE_EN
        check("master_opens", 32'(state), 32'd3);
        wait_stop(OPEN_N, "master_open_cycles");
`else
        check("master_rejected", 32'(state), 32'd4);
        idle();
`endif

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rrst = ($urandom_range(0, 499) == 0);
            rkv  = ($urandom_range(0, 9) < 4);
            pos  = m_digits.size();
            if ($urandom_range(0, 1) == 1 && pos < 4)
                rval = 4'((m_pw >> (4 * (3 - pos))) & 15);
            else
                rval = 4'($urandom_range(0, 15));
            rke  = ($urandom_range(0, 9) == 0);
            rkc  = ($urandom_range(0, 29) == 0);
            rsr  = ($urandom_range(0, 19) == 0);
            rdc  = ($urandom_range(0, 9) < 8);
            step(rrst, rkv, rval, rke, rkc, rsr, rdc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
